// File: rtl/prefetch_scheduler.sv
// Stride-prefetch scheduler: line-aligns and deduplicates RPT predictions into a
// circular queue and shares the single memory read port with demand misses.
module prefetch_scheduler #(
    parameter int DEPTH     = 4,
    parameter int LINE_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pf_valid,
    input  logic [31:0]              pf_addr,
    input  logic                     dm_read,
    input  logic [31:0]              dm_addr,
    output logic                     dm_resp,
    output logic                     mem_read,
    output logic [31:0]              mem_addr,
    input  logic                     mem_resp,
    output logic                     pf_fill,
    output logic [31:0]              pf_fill_addr,
    output logic                     queue_full,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] LMASK    = ~((32'd1 << LINE_BITS) - 32'd1);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH} state_t;

    state_t           r_state;
    logic [31:0]      r_req;
    logic [31:0]      r_q_addr [DEPTH];
    logic [DEPTH-1:0] r_q_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic [7:0]       r_drop;

    logic [31:0]      w_pf_line;
    logic [31:0]      w_dm_line;
    logic [DEPTH-1:0] w_pf_hit;
    logic [DEPTH-1:0] w_dm_hit;
    logic [DEPTH-1:0] w_vld_nxt;
    logic             w_full;
    logic             w_reject;
    logic             w_push;
    logic             w_pop;
    logic             w_merge;

    assign w_pf_line = pf_addr & LMASK;
    assign w_dm_line = dm_addr & LMASK;
    assign w_full    = (r_count == FULL_CNT);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_pf_hit[i] = r_q_vld[i] && (r_q_addr[i] == w_pf_line);
            w_dm_hit[i] = dm_read && r_q_vld[i] && (r_q_addr[i] == w_dm_line);
        end
    end

    // Full rejects even when a pop retires a slot this cycle; all compares use pre-edge state.
    assign w_reject = pf_valid && (w_full || (|w_pf_hit) ||
                      ((r_state == S_PREFETCH) && (w_pf_line == r_req)) ||
                      (dm_read && (w_pf_line == w_dm_line)));
    assign w_push   = pf_valid && !w_reject;
    assign w_pop    = (r_state == S_IDLE) && !dm_read && (r_count != '0);

    always_comb begin
        w_vld_nxt = r_q_vld & ~w_dm_hit;
        if (w_pop)
            w_vld_nxt[r_head] = 1'b0;
        if (w_push)
            w_vld_nxt[r_tail] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_vld <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_q_addr[i] <= '0;
        end else begin
            r_q_vld <= w_vld_nxt;
            if (w_push) begin
                r_q_addr[r_tail] <= w_pf_line;
                r_tail           <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_reject && (r_drop != 8'hFF))
                r_drop <= r_drop + 1'b1;
        end
    end

    // A squashed head is popped by w_pop but falls through here, costing one IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dm_read) begin
                        r_req   <= w_dm_line;
                        r_state <= S_DEMAND;
                    end else if ((r_count != '0) && r_q_vld[r_head]) begin
                        r_req   <= r_q_addr[r_head];
                        r_state <= S_PREFETCH;
                    end
                end
                S_DEMAND, S_PREFETCH: begin
                    if (mem_resp)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_merge      = (r_state == S_PREFETCH) && dm_read && (w_dm_line == r_req);

    assign mem_read     = (r_state != S_IDLE);
    assign mem_addr     = mem_read ? r_req : '0;
    assign dm_resp      = mem_resp && ((r_state == S_DEMAND) || w_merge);
    assign pf_fill      = mem_resp && (r_state == S_PREFETCH);
    assign pf_fill_addr = pf_fill ? r_req : '0;
    assign queue_full   = w_full;
    assign queue_count  = r_count;
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Bench for prefetch_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prefetch_scheduler;
    localparam int DEPTH = 4;
    localparam int LB    = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pf_valid = 1'b0;
    logic [31:0] pf_addr = '0;
    logic        dm_read = 1'b0;
    logic [31:0] dm_addr = '0;
    logic        dm_resp;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_resp = 1'b0;
    logic        pf_fill;
    logic [31:0] pf_fill_addr;
    logic        queue_full;
    logic [$clog2(DEPTH):0] queue_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    prefetch_scheduler #(.DEPTH(DEPTH), .LINE_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .pf_valid(pf_valid), .pf_addr(pf_addr),
        .dm_read(dm_read), .dm_addr(dm_addr), .dm_resp(dm_resp),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_resp(mem_resp),
        .pf_fill(pf_fill), .pf_fill_addr(pf_fill_addr),
        .queue_full(queue_full), .queue_count(queue_count), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] line;
        bit          vld;
    } ent_t;

    ent_t        mq[$];
    int          m_mode;     // 0 idle, 1 serving demand, 2 serving prefetch
    logic [31:0] m_req;
    int          m_drop;
    bit          e_dm_resp;

    function automatic logic [31:0] ln(logic [31:0] a);
        return a & ~((32'd1 << LB) - 32'd1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0;
        m_req  = '0;
        m_drop = 0;
    endtask

    task automatic model_step();
        logic [31:0] pl, dl;
        bit dup, rej;
        ent_t e;
        pl  = ln(pf_addr);
        dl  = ln(dm_addr);
        dup = 0;
        foreach (mq[i]) if (mq[i].vld && mq[i].line == pl) dup = 1;
        rej = pf_valid && (mq.size() == DEPTH || dup ||
              (m_mode == 2 && pl == m_req) || (dm_read && pl == dl));
        if (dm_read) foreach (mq[i]) if (mq[i].line == dl) mq[i].vld = 0;
        if (m_mode == 0) begin
            if (dm_read) begin
                m_req = dl; m_mode = 1;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.vld) begin m_req = e.line; m_mode = 2; end
            end
        end else if (mem_resp) begin
            m_mode = 0;
        end
        if (pf_valid && !rej) mq.push_back('{pl, 1'b1});
        if (rej && m_drop < 255) m_drop++;
    endtask

    always @(posedge clk) if (rst_n) model_step();

    task automatic model_cmp();
        bit fill;
        fill      = mem_resp && (m_mode == 2);
        e_dm_resp = mem_resp && (m_mode == 1 || (m_mode == 2 && dm_read && ln(dm_addr) == m_req));
        chk("mem_read", mem_read, m_mode != 0);
        if (m_mode != 0) chk("mem_addr", mem_addr, m_req);
        chk("dm_resp", dm_resp, e_dm_resp);
        chk("pf_fill", pf_fill, fill);
        if (fill) chk("pf_fill_addr", pf_fill_addr, m_req);
        chk("queue_count", queue_count, mq.size());
        chk("queue_full", queue_full, mq.size() == DEPTH);
        chk("drop_count", drop_count, m_drop);
    endtask

    task automatic cyc(bit pv, logic [31:0] pa, bit dr, logic [31:0] da, bit mr);
        @(negedge clk);
        pf_valid = pv; pf_addr = pa; dm_read = dr; dm_addr = da; mem_resp = mr;
        #1;
        model_cmp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        pf_valid = 0; pf_addr = '0; dm_read = 0; dm_addr = '0; mem_resp = 0;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_count", queue_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic serve(logic [31:0] exp);
        int n = 0;
        cyc(0, 0, 0, 0, 0);
        while (!mem_read && n < 10) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("issue_seen", mem_read, 1);
        chk("issue_addr", mem_addr, exp);
        cyc(0, 0, 0, 0, 1);
        chk("issue_fill", pf_fill, 1);
        chk("issue_fill_addr", pf_fill_addr, exp);
    endtask

    initial begin
        bit          dm_act;
        logic [31:0] dm_a;
        bit          stall;
        bit          pv, mr;
        logic [31:0] pa;

        // Single prefetch round trip.
        do_reset();
        cyc(1, 32'h1234, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_count_before_pop", queue_count, 1);
        chk("t1_no_read_yet", mem_read, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_read", mem_read, 1);
        chk("t1_addr", mem_addr, 32'h1220);
        cyc(0, 0, 0, 0, 1);
        chk("t1_fill", pf_fill, 1);
        chk("t1_fill_addr", pf_fill_addr, 32'h1220);
        cyc(0, 0, 0, 0, 0);
        chk("t1_count_end", queue_count, 0);

        // Overflow with the port held by a stalled demand.
        do_reset();
        cyc(0, 0, 1, 32'h9000, 0);
        for (int k = 1; k <= 5; k++) cyc(1, k * 32'h100, 1, 32'h9000, 0);
        cyc(0, 0, 1, 32'h9000, 0);
        chk("t2_full", queue_full, 1);
        chk("t2_drop", drop_count, 1);
        cyc(0, 0, 1, 32'h9000, 1);
        chk("t2_dm_resp", dm_resp, 1);
        for (int k = 1; k <= 4; k++) serve(k * 32'h100);
        cyc(0, 0, 0, 0, 0);
        chk("t2_count_end", queue_count, 0);

        // Duplicate line rejection.
        do_reset();
        cyc(0, 0, 1, 32'h9000, 0);
        cyc(1, 32'h1000, 1, 32'h9000, 0);
        cyc(1, 32'h101C, 1, 32'h9000, 0);
        cyc(0, 0, 1, 32'h9000, 0);
        chk("t3_drop", drop_count, 1);
        chk("t3_count", queue_count, 1);
        cyc(0, 0, 1, 32'h9000, 1);
        serve(32'h1000);

        // Demand squashes a queued entry behind an in-flight prefetch.
        do_reset();
        cyc(1, 32'h3000, 0, 0, 0);
        cyc(1, 32'h2000, 0, 0, 0);
        cyc(0, 0, 1, 32'h2004, 0);
        chk("t4_pf_addr", mem_addr, 32'h3000);
        chk("t4_count", queue_count, 1);
        cyc(0, 0, 1, 32'h2004, 1);
        chk("t4_pf_fill", pf_fill, 1);
        chk("t4_pf_fill_addr", pf_fill_addr, 32'h3000);
        chk("t4_no_merge", dm_resp, 0);
        cyc(0, 0, 1, 32'h2004, 0);
        chk("t4_idle_gap", mem_read, 0);
        cyc(0, 0, 1, 32'h2004, 1);
        chk("t4_dm_addr", mem_addr, 32'h2000);
        chk("t4_dm_resp", dm_resp, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_squashed_slot", queue_count, 1);
        chk("t4_no_reissue_a", mem_read, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_no_reissue_b", mem_read, 0);
        chk("t4_count_end", queue_count, 0);

        // Demand merges into the matching in-flight prefetch.
        do_reset();
        cyc(1, 32'h4000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h4010, 0);
        chk("t5_addr", mem_addr, 32'h4000);
        cyc(0, 0, 1, 32'h4010, 1);
        chk("t5_dm_resp", dm_resp, 1);
        chk("t5_pf_fill", pf_fill, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_no_extra_read", mem_read, 0);

        // Asynchronous reset in the middle of a demand.
        do_reset();
        cyc(1, 32'h5000, 1, 32'h5000, 0);
        cyc(0, 0, 1, 32'h5000, 0);
        chk("t6_demand_read", mem_read, 1);
        chk("t6_drop_before", drop_count, 1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("t6_async_read", mem_read, 0);
        chk("t6_async_count", queue_count, 0);
        chk("t6_async_drop", drop_count, 0);
        @(negedge clk);
        dm_read = 0; dm_addr = '0;
        rst_n = 1;
        cyc(0, 0, 0, 0, 1);
        chk("t6_late_dm_resp", dm_resp, 0);
        chk("t6_late_pf_fill", pf_fill, 0);

        // Randomized traffic over a small set of lines to provoke duplicates and squashes.
        do_reset();
        dm_act = 0;
        dm_a   = '0;
        for (int c = 0; c < 4000; c++) begin
            stall = ((c / 64) % 4) == 3;
            if (!dm_act && $urandom_range(0, 9) == 0) begin
                dm_act = 1;
                dm_a   = 32'h1000 + ($urandom_range(0, 7) << 8) + $urandom_range(0, 31);
            end
            pv = ($urandom_range(0, 1) == 1);
            pa = 32'h1000 + ($urandom_range(0, 7) << 8) + $urandom_range(0, 31);
            mr = (m_mode != 0) ? (!stall && $urandom_range(0, 2) == 0)
                               : ($urandom_range(0, 15) == 0);
            cyc(pv, pa, dm_act, dm_a, mr);
            if (e_dm_resp) dm_act = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
